// File: rtl/cmd_arbiter.sv
// Round-robin arbiter sharing one UART command-sender among NUM_REQ requesters.
// The winner's command is latched and a single-cycle snd_cmd is issued. The
// command is then held until cmd_cmplt arrives or the watchdog expires, and
// the granted requester receives a done pulse.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no transaction; arbitrate among req starting at ptr
//   ISSUE | snd_cmd high for one cycle; command latched on cmd
//   WAIT  | waiting for cmd_cmplt; watchdog counts up
//   FIN   | done (and to_err on timeout) high for one cycle
module cmd_arbiter #(
    parameter int unsigned         NUM_REQ   = 4,
    parameter int unsigned         CMD_W     = 16,
    parameter int unsigned         TO_W      = 20,
    parameter logic [TO_W-1:0]     TO_CYCLES = 20'hF_FFFF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*CMD_W-1:0]   req_cmd,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [NUM_REQ-1:0]         done,
    output logic                       to_err,
    output logic                       snd_cmd,
    output logic [CMD_W-1:0]           cmd,
    input  logic                       cmd_cmplt,
    output logic                       busy
);

    localparam int unsigned     PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [TO_W-1:0] WD_LAST = TO_CYCLES - 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t               state, state_nxt;
    logic [PTR_W-1:0]     ptr, ptr_nxt;
    logic [PTR_W-1:0]     gnt_idx, gnt_idx_nxt;
    logic [TO_W-1:0]      wdog, wdog_nxt;
    logic [NUM_REQ-1:0]   gnt_nxt, done_nxt;
    logic                 to_err_nxt, snd_cmd_nxt, busy_nxt;
    logic [CMD_W-1:0]     cmd_nxt;

    // arbitration results
    logic                 win_vld;
    logic [PTR_W-1:0]     win_idx;
    logic [NUM_REQ-1:0]   win_oh;
    logic [CMD_W-1:0]     win_cmd;
    logic [PTR_W:0]       cand;

    // Rotating priority search: first requester at or after ptr, wrapping.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        win_oh  = '0;
        win_cmd = '0;
        cand    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr} + (PTR_W+1)'(k);
            if (cand >= (PTR_W+1)'(NUM_REQ)) begin
                cand = cand - (PTR_W+1)'(NUM_REQ);
            end
            if (!win_vld && req[cand[PTR_W-1:0]]) begin
                win_vld = 1'b1;
                win_idx = cand[PTR_W-1:0];
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_vld && (win_idx == PTR_W'(i))) begin
                win_oh[i] = 1'b1;
                win_cmd   = req_cmd[i*CMD_W +: CMD_W];
            end
        end
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        gnt_idx_nxt = gnt_idx;
        wdog_nxt    = wdog;
        gnt_nxt     = gnt;
        done_nxt    = '0;
        to_err_nxt  = 1'b0;
        snd_cmd_nxt = 1'b0;
        busy_nxt    = busy;
        cmd_nxt     = cmd;

        case (state)
            IDLE: begin
                if (win_vld) begin
                    gnt_nxt     = win_oh;
                    gnt_idx_nxt = win_idx;
                    cmd_nxt     = win_cmd;
                    snd_cmd_nxt = 1'b1;
                    busy_nxt    = 1'b1;
                    state_nxt   = ISSUE;
                end
            end
            ISSUE: begin
                wdog_nxt  = '0;
                state_nxt = WAIT;
            end
            WAIT: begin
                wdog_nxt = wdog + 1'b1;
                // completion takes precedence over a coincident expiry
                if (cmd_cmplt) begin
                    done_nxt  = gnt;
                    state_nxt = FIN;
                end else if (wdog == WD_LAST) begin
                    done_nxt   = gnt;
                    to_err_nxt = 1'b1;
                    state_nxt  = FIN;
                end
            end
            FIN: begin
                gnt_nxt  = '0;
                busy_nxt = 1'b0;
                if (gnt_idx == PTR_W'(NUM_REQ-1)) begin
                    ptr_nxt = '0;
                end else begin
                    ptr_nxt = gnt_idx + 1'b1;
                end
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            gnt_idx <= '0;
            wdog    <= '0;
            gnt     <= '0;
            done    <= '0;
            to_err  <= 1'b0;
            snd_cmd <= 1'b0;
            busy    <= 1'b0;
            cmd     <= '0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            gnt_idx <= gnt_idx_nxt;
            wdog    <= wdog_nxt;
            gnt     <= gnt_nxt;
            done    <= done_nxt;
            to_err  <= to_err_nxt;
            snd_cmd <= snd_cmd_nxt;
            busy    <= busy_nxt;
            cmd     <= cmd_nxt;
        end
    end

endmodule

// File: tb/tb_cmd_arbiter.sv
// Directed testbench for cmd_arbiter (NUM_REQ=4, TO_CYCLES=50).
// Inputs are driven and outputs sampled on the falling edge of clk.
module tb_cmd_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [63:0] req_cmd;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        to_err;
    logic        snd_cmd;
    logic [15:0] cmd;
    logic        cmd_cmplt;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    cmd_arbiter #(
        .NUM_REQ   (4),
        .CMD_W     (16),
        .TO_W      (20),
        .TO_CYCLES (20'd50)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_cmd   (req_cmd),
        .gnt       (gnt),
        .done      (done),
        .to_err    (to_err),
        .snd_cmd   (snd_cmd),
        .cmd       (cmd),
        .cmd_cmplt (cmd_cmplt),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Wait up to max cycles for snd_cmd; n = cycles taken, or max+1 if none.
    task automatic wait_snd(input int max, output int n);
        n = max + 1;
        for (int i = 1; i <= max; i++) begin
            tick();
            if (snd_cmd) begin
                n = i;
                break;
            end
        end
    endtask

    function automatic logic [15:0] cval(input int i);
        return 16'h1000 + 16'(i) * 16'h0111;
    endfunction

    int n;
    int cnt;
    int exp_i;

    initial begin
        rst       = 1'b1;
        req       = '0;
        req_cmd   = '0;
        cmd_cmplt = 1'b0;

        // reset and idle
        repeat (3) tick();
        chk("rst_outs", {5'd0, gnt, done, to_err, snd_cmd, busy, cmd}, 32'd0);
        rst = 1'b0;
        cnt = 0;
        repeat (20) begin
            tick();
            if (snd_cmd) cnt++;
        end
        chk("idle_no_snd", cnt, 0);

        // round robin, all four requesting; ptr starts at 0
        for (int i = 0; i < 4; i++) req_cmd[i*16 +: 16] = cval(i);
        req = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            exp_i = t % 4;
            wait_snd(10, n);
            chk("rr_lat", n, (t == 0) ? 1 : 2);
            chk("rr_gnt", gnt, 32'd1 << exp_i);
            chk("rr_cmd", cmd, cval(exp_i));
            chk("rr_busy", busy, 1);
            repeat (4) tick();
            cmd_cmplt = 1'b1;
            tick();
            cmd_cmplt = 1'b0;
            chk("rr_done", done, 32'd1 << exp_i);
            chk("rr_to_err", to_err, 0);
        end
        req = '0;
        tick();
        chk("rr_end", {gnt, done, busy}, 0);

        // single request, index 1 (ptr is now 1)
        req_cmd[16 +: 16] = 16'hA55A;
        req = 4'b0010;
        wait_snd(10, n);
        chk("one_lat", n, 1);
        chk("one_gnt", gnt, 4'b0010);
        chk("one_cmd", cmd, 16'hA55A);
        repeat (9) tick();
        chk("one_pre_done", done, 0);
        cmd_cmplt = 1'b1;
        tick();
        cmd_cmplt = 1'b0;
        chk("one_done", done, 4'b0010);
        chk("one_to_err", to_err, 0);
        chk("one_cmd_hold", cmd, 16'hA55A);
        req = '0;
        tick();
        chk("one_end", {gnt, done, busy}, 0);

        // timeout on index 2 (ptr is now 2)
        req_cmd[32 +: 16] = 16'h2BAD;
        req = 4'b0100;
        wait_snd(10, n);
        chk("to_lat", n, 1);
        chk("to_gnt", gnt, 4'b0100);
        n = 101;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (done != 0) begin
                n = i;
                break;
            end
        end
        chk("to_done_lat", n, 51);
        chk("to_done", done, 4'b0100);
        chk("to_err_set", to_err, 1);
        // ptr must now be 3: with 0 and 3 both requesting, 3 wins
        req_cmd[0 +: 16]  = 16'h0C0C;
        req_cmd[48 +: 16] = 16'h3C3C;
        req = 4'b1001;
        wait_snd(10, n);
        chk("to_next_lat", n, 2);
        chk("to_next_gnt", gnt, 4'b1000);
        chk("to_next_cmd", cmd, 16'h3C3C);
        tick();
        cmd_cmplt = 1'b1;
        tick();
        cmd_cmplt = 1'b0;
        chk("to_next_done", done, 4'b1000);
        chk("to_next_err", to_err, 0);

        // completion on the expiry cycle: completion wins (ptr is now 0)
        req = 4'b0001;
        wait_snd(10, n);
        chk("col_lat", n, 2);
        chk("col_gnt", gnt, 4'b0001);
        repeat (50) tick();
        chk("col_pre_done", done, 0);
        cmd_cmplt = 1'b1;
        tick();
        cmd_cmplt = 1'b0;
        chk("col_done", done, 4'b0001);
        chk("col_to_err", to_err, 0);
        req = '0;
        tick();
        // stray completion in IDLE
        cmd_cmplt = 1'b1;
        tick();
        cmd_cmplt = 1'b0;
        repeat (3) begin
            chk("stray_idle", {gnt, done, to_err, snd_cmd, busy}, 0);
            tick();
        end

        // reset during WAIT (ptr is now 1, index 1 granted)
        req = 4'b0010;
        wait_snd(10, n);
        chk("rmid_lat", n, 1);
        chk("rmid_gnt", gnt, 4'b0010);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rmid_outs", {5'd0, gnt, done, to_err, snd_cmd, busy, cmd}, 32'd0);
        // ptr back at 0: index 0 beats index 3
        req = 4'b1001;
        wait_snd(10, n);
        chk("rmid_re_lat", n, 1);
        chk("rmid_re_gnt", gnt, 4'b0001);
        chk("rmid_no_done", done, 0);
        tick();
        cmd_cmplt = 1'b1;
        tick();
        cmd_cmplt = 1'b0;
        chk("rmid_re_done", done, 4'b0001);
        req = '0;
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
